// File: rtl/cmp_track_if.sv
// Stream bundle for cmp_track: frame control, sample input and frame-result output.
// Index fields (and the CNT_W parameter) exist only when CMP_TRACK_INDEX_EN is defined.
interface cmp_track_if #(
  parameter int WIDTH = 8
`ifdef CMP_TRACK_INDEX_EN
  , parameter int CNT_W = 5
`endif
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] min_val;
  logic             busy;
`ifdef CMP_TRACK_INDEX_EN
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] min_idx;
`endif

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_val, min_val, busy
`ifdef CMP_TRACK_INDEX_EN
    , input max_idx, min_idx
`endif
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, max_val, min_val, busy
`ifdef CMP_TRACK_INDEX_EN
    , output max_idx, min_idx
`endif
  );
endinterface

// File: rtl/cmp_track.sv
// Streaming unsigned min/max tracker over a FRAME_LEN-sample frame.
// Optional feature macro: CMP_TRACK_INDEX_EN adds max_idx/min_idx outputs.
//
// state | meaning
// IDLE  | waiting for start; results from last frame held
// RUN   | accepting samples, tracking running max/min
// HOLD  | frame result presented until out_ready
module cmp_track #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN) + 1
) (
  input logic        clk,
  input logic        rst_n,
  cmp_track_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.max_val   <= '0;
      bus.min_val   <= '0;
`ifdef CMP_TRACK_INDEX_EN
      bus.max_idx   <= '0;
      bus.min_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RUN;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            // First sample seeds both trackers; later ones need a strict win.
            if (cnt == '0) begin
              bus.max_val <= bus.in_data;
              bus.min_val <= bus.in_data;
`ifdef CMP_TRACK_INDEX_EN
              bus.max_idx <= '0;
              bus.min_idx <= '0;
`endif
            end else begin
              if (bus.in_data > bus.max_val) begin
                bus.max_val <= bus.in_data;
`ifdef CMP_TRACK_INDEX_EN
                bus.max_idx <= cnt;
`endif
              end
              if (bus.in_data < bus.min_val) begin
                bus.min_val <= bus.in_data;
`ifdef CMP_TRACK_INDEX_EN
                bus.min_idx <= cnt;
`endif
              end
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b0;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_track.sv
// Directed bench for cmp_track (FRAME_LEN=4) with a result scoreboard.
// Index checks are enabled when CMP_TRACK_INDEX_EN is defined.
module tb_cmp_track;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef CMP_TRACK_INDEX_EN
  cmp_track_if #(.WIDTH(WIDTH), .CNT_W(3)) bus ();
`else
  cmp_track_if #(.WIDTH(WIDTH)) bus ();
`endif

  cmp_track #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    int         mxi;
    int         mni;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] mx, input logic [7:0] mn, input int mxi, input int mni);
    exp_t e;
    e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expected result per output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%0h/0x%0h, expected none", bus.max_val, bus.min_val);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pops++;
        check("sb_max_val", int'(bus.max_val), int'(e.mx));
        check("sb_min_val", int'(bus.min_val), int'(e.mn));
`ifdef CMP_TRACK_INDEX_EN
        check("sb_max_idx", int'(bus.max_idx), e.mxi);
        check("sb_min_idx", int'(bus.min_idx), e.mni);
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_max_val"},   int'(bus.max_val),   0);
    check({tag, "_min_val"},   int'(bus.min_val),   0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_in_ready"},  int'(bus.in_ready),  0);
    check({tag, "_busy"},      int'(bus.busy),      0);
`ifdef CMP_TRACK_INDEX_EN
    check({tag, "_max_idx"},   int'(bus.max_idx),   0);
    check({tag, "_min_idx"},   int'(bus.min_idx),   0);
`endif
  endtask

  task automatic open_frame;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("in_ready_after_start", int'(bus.in_ready), 1);
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic feed(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic feed4(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    feed(d0);
    feed(d1);
    feed(d2);
    check("out_valid_before_last", int'(bus.out_valid), 0);
    feed(d3);
    check("out_valid_after_last", int'(bus.out_valid), 1);
    check("in_ready_in_hold", int'(bus.in_ready), 0);
  endtask

  task automatic release_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_after_hs", int'(bus.out_valid), 0);
    check("busy_after_hs", int'(bus.busy), 0);
  endtask

  initial begin
    bit         vpat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [7:0] samp[4] = '{8'h10, 8'h20, 8'h05, 8'h30};
    int         k;

    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Frame 1: mixed values
    push_exp(8'hFF, 8'h01, 2, 1);
    open_frame();
    feed4(8'h80, 8'h01, 8'hFF, 8'h80);
    check("f1_max_in_hold", int'(bus.max_val), 8'hFF);
    release_result();

    // IDLE: results held, in_valid ignored
    bus.in_valid = 1'b1; bus.in_data = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    check("idle_in_ready", int'(bus.in_ready), 0);
    check("idle_max_held", int'(bus.max_val), 8'hFF);
    check("idle_min_held", int'(bus.min_val), 8'h01);

    // Frame 2: all equal, then stall in HOLD with start/in_valid noise
    push_exp(8'h80, 8'h80, 0, 0);
    open_frame();
    feed4(8'h80, 8'h80, 8'h80, 8'h80);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h00;
      tick();
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_in_ready", int'(bus.in_ready), 0);
      check("stall_max", int'(bus.max_val), 8'h80);
      check("stall_min", int'(bus.min_val), 8'h80);
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    release_result();

    // Frame 3: gapped in_valid; 0xEE on idle cycles must never be taken
    push_exp(8'h30, 8'h05, 3, 2);
    open_frame();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = vpat[i];
      bus.in_data  = vpat[i] ? samp[k] : 8'hEE;
      if (vpat[i]) k++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("gap_out_valid", int'(bus.out_valid), 1);
    release_result();

    // Frame 4: start during RUN after 2 accepts is ignored
    push_exp(8'h60, 8'h30, 3, 2);
    open_frame();
    feed(8'h40);
    feed(8'h50);
    bus.start = 1'b1;
    feed(8'h30);
    bus.start = 1'b0;
    check("restart_out_valid_early", int'(bus.out_valid), 0);
    feed(8'h60);
    check("restart_out_valid", int'(bus.out_valid), 1);
    release_result();

    // Async reset mid-frame
    open_frame();
    feed(8'h11);
    bus.in_valid = 1'b1; bus.in_data = 8'h22;
    tick();
    check("pre_reset_max", int'(bus.max_val), 8'h22);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all_zero("post_release");

    // Frame 5: after reset
    push_exp(8'h7F, 8'h00, 1, 0);
    open_frame();
    feed4(8'h00, 8'h7F, 8'h7F, 8'h01);
    release_result();

    tick();
    tick();
    check("sb_pending", exp_q.size(), 0);
    check("sb_pops", pops, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
